// File: rtl/monitor_capture_packer.sv
// ---------------------------------------------------------------------------
// monitor_capture_packer
//
// Purpose:
//   FPGA-side consumer of the ASIC monitor port. Enables the monitor for a
//   capture of I_cap_len bytes, packs the incoming monitor bytes into
//   LANES-byte words (byte k in bits [8k+7:8k]) and streams them out on a
//   valid/ready interface through a 2-entry output FIFO.
//
// Optional feature (compile-time macro):
//   MON_TIMEOUT_FLUSH_EN - when defined, a partially filled word is pushed
//   (last = 0) after TIMEOUT consecutive cycles in CAPTURE without an
//   accepted byte. When undefined the idle counter does not exist.
//
// Handshake:
//   A word transfers on a cycle where O_word_vld = 1 and I_word_rdy = 1.
//   While O_word_vld = 1 and I_word_rdy = 0, O_word / O_word_keep /
//   O_word_last stay stable. O_word_vld never drops without a transfer,
//   except on I_abort or reset. The monitor input side has no back-pressure:
//   a byte is taken on every cycle with O_Monitor_En = 1 and
//   I_Monitor_OutVld = 1.
//
// Ports:
//   I_clk, I_rst          clock, asynchronous active-high reset
//   I_start, I_abort      capture start pulse (IDLE only) / cancel pulse
//   I_cap_len             capture length in bytes, latched on I_start
//   O_Monitor_En          enable to the ASIC monitor (high in CAPTURE)
//   I_Monitor_Out/OutVld  monitor byte and its valid strobe
//   O_word/_keep/_last    packed word, byte-enable mask, final-word flag
//   O_word_vld/I_word_rdy output stream handshake
//   O_busy, O_done        not-IDLE flag / one-cycle completion pulse
//   O_overflow            sticky: a completed word was dropped
//   O_byte_cnt            bytes accepted in the current capture
//   O_dbg_state           FSM state (0 IDLE, 1 CAPTURE, 2 DRAIN, 3 DONE)
// ---------------------------------------------------------------------------
module monitor_capture_packer #(
   parameter int BYTE_W  = 8,
   parameter int LANES   = 16,
   parameter int LEN_W   = 16,
   parameter int TIMEOUT = 1024
) (
   input  logic                    I_clk,
   input  logic                    I_rst,
   input  logic                    I_start,
   input  logic                    I_abort,
   input  logic [LEN_W-1:0]        I_cap_len,
   output logic                    O_Monitor_En,
   input  logic [BYTE_W-1:0]       I_Monitor_Out,
   input  logic                    I_Monitor_OutVld,
   output logic [BYTE_W*LANES-1:0] O_word,
   output logic [LANES-1:0]        O_word_keep,
   output logic                    O_word_last,
   output logic                    O_word_vld,
   input  logic                    I_word_rdy,
   output logic                    O_busy,
   output logic                    O_done,
   output logic                    O_overflow,
   output logic [LEN_W-1:0]        O_byte_cnt,
   output logic [1:0]              O_dbg_state
);

   localparam int OUT_W = BYTE_W * LANES;
   localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CAPTURE = 2'd1,
      ST_DRAIN   = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   state_t state_q, state_d;

   // capture bookkeeping
   logic [LEN_W-1:0] len_q;
   logic [LEN_W-1:0] byte_cnt_q;
   logic [IDX_W-1:0] idx_q;
   logic [OUT_W-1:0] data_q;

   // output FIFO (2 entries)
   logic [OUT_W-1:0] fifo_data [2];
   logic [LANES-1:0] fifo_keep [2];
   logic             fifo_last [2];
   logic             rd_ptr_q;
   logic [1:0]       count_q;
   logic             overflow_q;

   // datapath controls
   logic             start_ok;
   logic             accept;
   logic             is_last;
   logic             word_full;
   logic             flush;
   logic             push;
   logic             pop;
   logic             full;
   logic             push_ok;
   logic             drop;
   logic             wr_sel;
   logic [OUT_W-1:0] asm_word;
   logic [LANES-1:0] push_keep;

   assign start_ok  = (state_q == ST_IDLE) && I_start && !I_abort;
   assign accept    = (state_q == ST_CAPTURE) && I_Monitor_OutVld && !I_abort;
   assign is_last   = accept && ((byte_cnt_q + LEN_W'(1)) == len_q);
   assign word_full = accept && (idx_q == IDX_W'(LANES - 1));
   assign push      = (accept && (word_full || is_last)) || flush;

   assign full      = (count_q == 2'd2);
   assign pop       = (count_q != 2'd0) && I_word_rdy;
   assign push_ok   = push && (!full || pop);
   // Full with no pop: non-final words are lost, the final word replaces
   // the newest entry so the capture can still finish.
   assign drop      = push && full && !pop && !is_last;
   // Next free slot is rd_ptr + count (mod 2); with a pop on a full FIFO
   // this is the slot being vacated.
   assign wr_sel    = rd_ptr_q ^ count_q[0];

`ifdef MON_TIMEOUT_FLUSH_EN
   localparam int IDLE_W = $clog2(TIMEOUT + 1);
   logic [IDLE_W-1:0] idle_q;

   assign flush = (state_q == ST_CAPTURE) && !I_Monitor_OutVld && !I_abort &&
                  (idx_q != '0) && (idle_q == IDLE_W'(TIMEOUT - 1));

   always_ff @(posedge I_clk or posedge I_rst) begin
      if (I_rst) begin
         idle_q <= '0;
      end else if (I_abort || start_ok || accept || flush) begin
         idle_q <= '0;
      end else if ((state_q == ST_CAPTURE) && (idle_q != IDLE_W'(TIMEOUT - 1))) begin
         idle_q <= idle_q + IDLE_W'(1);
      end
   end
`else
   assign flush = 1'b0;
`endif

   // Word being assembled this cycle, including the incoming byte.
   always_comb begin
      asm_word = data_q;
      if (accept) begin
         asm_word[idx_q*BYTE_W +: BYTE_W] = I_Monitor_Out;
      end
   end

   // A byte push covers lanes 0..idx; a timeout flush covers only the lanes
   // already filled, 0..idx-1.
   always_comb begin
      push_keep = '0;
      for (int k = 0; k < LANES; k++) begin
         if (flush) begin
            push_keep[k] = (IDX_W'(k) < idx_q);
         end else begin
            push_keep[k] = (IDX_W'(k) <= idx_q);
         end
      end
   end

   // ---------------- FSM: state register ----------------
   always_ff @(posedge I_clk or posedge I_rst) begin
      if (I_rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------- FSM: next-state ----------------
   always_comb begin
      state_d = state_q;
      if (I_abort) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (I_start) begin
                  state_d = (I_cap_len == '0) ? ST_DONE : ST_CAPTURE;
               end
            end
            ST_CAPTURE: begin
               if (is_last) begin
                  state_d = ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (count_q == 2'd0) begin
                  state_d = ST_DONE;
               end
            end
            ST_DONE: begin
               state_d = ST_IDLE;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      O_Monitor_En = 1'b0;
      O_busy       = 1'b0;
      O_done       = 1'b0;
      case (state_q)
         ST_CAPTURE: begin
            O_Monitor_En = 1'b1;
            O_busy       = 1'b1;
         end
         ST_DRAIN: begin
            O_busy = 1'b1;
         end
         ST_DONE: begin
            O_busy = 1'b1;
            O_done = 1'b1;
         end
         default: begin
            O_busy = 1'b0;
         end
      endcase
   end

   // ---------------- capture bookkeeping ----------------
   always_ff @(posedge I_clk or posedge I_rst) begin
      if (I_rst) begin
         len_q      <= '0;
         byte_cnt_q <= '0;
         idx_q      <= '0;
         data_q     <= '0;
      end else if (I_abort) begin
         idx_q  <= '0;
         data_q <= '0;
      end else if (start_ok) begin
         len_q      <= I_cap_len;
         byte_cnt_q <= '0;
         idx_q      <= '0;
         data_q     <= '0;
      end else begin
         if (accept) begin
            byte_cnt_q <= byte_cnt_q + LEN_W'(1);
         end
         if (push) begin
            // lanes restart at 0 with unused lanes zeroed
            idx_q  <= '0;
            data_q <= '0;
         end else if (accept) begin
            idx_q  <= idx_q + IDX_W'(1);
            data_q <= asm_word;
         end
      end
   end

   // ---------------- output FIFO ----------------
   always_ff @(posedge I_clk or posedge I_rst) begin
      if (I_rst) begin
         rd_ptr_q     <= 1'b0;
         count_q      <= 2'd0;
         fifo_data[0] <= '0;
         fifo_data[1] <= '0;
         fifo_keep[0] <= '0;
         fifo_keep[1] <= '0;
         fifo_last[0] <= 1'b0;
         fifo_last[1] <= 1'b0;
      end else if (I_abort) begin
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (push_ok) begin
            fifo_data[wr_sel] <= asm_word;
            fifo_keep[wr_sel] <= push_keep;
            fifo_last[wr_sel] <= is_last;
         end else if (push && is_last) begin
            fifo_data[~rd_ptr_q] <= asm_word;
            fifo_keep[~rd_ptr_q] <= push_keep;
            fifo_last[~rd_ptr_q] <= 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         count_q <= count_q + {1'b0, push_ok} - {1'b0, pop};
      end
   end

   always_ff @(posedge I_clk or posedge I_rst) begin
      if (I_rst) begin
         overflow_q <= 1'b0;
      end else if (start_ok) begin
         overflow_q <= 1'b0;
      end else if (drop) begin
         overflow_q <= 1'b1;
      end
   end

   assign O_word      = fifo_data[rd_ptr_q];
   assign O_word_keep = fifo_keep[rd_ptr_q];
   assign O_word_last = fifo_last[rd_ptr_q];
   assign O_word_vld  = (count_q != 2'd0);
   assign O_overflow  = overflow_q;
   assign O_byte_cnt  = byte_cnt_q;
   assign O_dbg_state = state_q;

endmodule

// File: tb/tb_monitor_capture_packer.sv
module tb_monitor_capture_packer;

   localparam int EW = 1 + 16 + 128;  // {last, keep, data}

   logic         I_clk;
   logic         I_rst;
   logic         I_start;
   logic         I_abort;
   logic [15:0]  I_cap_len;
   logic         O_Monitor_En;
   logic [7:0]   I_Monitor_Out;
   logic         I_Monitor_OutVld;
   logic [127:0] O_word;
   logic [15:0]  O_word_keep;
   logic         O_word_last;
   logic         O_word_vld;
   logic         I_word_rdy;
   logic         O_busy;
   logic         O_done;
   logic         O_overflow;
   logic [15:0]  O_byte_cnt;
   logic [1:0]   O_dbg_state;

   int errors;
   int checks;
   int en_cycles;
   int done_cnt;

   // scoreboard and packing model
   logic [EW-1:0]  exp_q[$];
   logic [EW-1:0]  exp_e;
   logic [127:0]   m_data;
   logic [15:0]    m_keep;
   int             m_lane;
   int             m_cnt;
   logic           exp_ovf;

   monitor_capture_packer #(
      .BYTE_W (8),
      .LANES  (16),
      .LEN_W  (16),
      .TIMEOUT(8)
   ) dut (
      .I_clk           (I_clk),
      .I_rst           (I_rst),
      .I_start         (I_start),
      .I_abort         (I_abort),
      .I_cap_len       (I_cap_len),
      .O_Monitor_En    (O_Monitor_En),
      .I_Monitor_Out   (I_Monitor_Out),
      .I_Monitor_OutVld(I_Monitor_OutVld),
      .O_word          (O_word),
      .O_word_keep     (O_word_keep),
      .O_word_last     (O_word_last),
      .O_word_vld      (O_word_vld),
      .I_word_rdy      (I_word_rdy),
      .O_busy          (O_busy),
      .O_done          (O_done),
      .O_overflow      (O_overflow),
      .O_byte_cnt      (O_byte_cnt),
      .O_dbg_state     (O_dbg_state)
   );

   // ---------------- clock ----------------
   initial I_clk = 1'b0;
   always #5 I_clk = ~I_clk;

   // One cycle: sample on the falling edge (scoreboard, counters), then
   // advance past the rising edge so inputs can be driven.
   task automatic tick();
      @(negedge I_clk);
      if (!I_rst) begin
         if (O_Monitor_En) en_cycles++;
         if (O_done) done_cnt++;
         if (O_word_vld && I_word_rdy) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL sb_unexpected: got last=%b keep=%h word=%h, want no word",
                        O_word_last, O_word_keep, O_word);
            end else begin
               exp_e = exp_q.pop_front();
               if ({O_word_last, O_word_keep, O_word} !== exp_e) begin
                  errors++;
                  $display("FAIL sb_word: got last=%b keep=%h word=%h, want last=%b keep=%h word=%h",
                           O_word_last, O_word_keep, O_word, exp_e[144], exp_e[143:128], exp_e[127:0]);
               end
            end
         end
      end
      @(posedge I_clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // ---------------- driver tasks ----------------
   task automatic start_capture(input logic [15:0] len);
      m_data    = '0;
      m_keep    = '0;
      m_lane    = 0;
      m_cnt     = 0;
      exp_ovf   = 1'b0;
      I_cap_len = len;
      I_start   = 1'b1;
      tick();
      I_start   = 1'b0;
   endtask

   // Expected-word push; with hold=1 the reader is stalled, so model the
   // 2-entry buffer: drop when full, except the final word replaces the newest.
   task automatic push_exp(input logic [EW-1:0] e, input bit hold);
      if (!hold || exp_q.size() < 2) begin
         exp_q.push_back(e);
      end else if (e[144]) begin
         exp_q[exp_q.size() - 1] = e;
      end else begin
         exp_ovf = 1'b1;
      end
   endtask

   task automatic send_bytes(input int n, input logic [7:0] base, input int len, input bit hold);
      logic [7:0] b;
      for (int i = 0; i < n; i++) begin
         b = base + 8'(i);
         I_Monitor_Out    = b;
         I_Monitor_OutVld = 1'b1;
         m_data[m_lane*8 +: 8] = b;
         m_keep[m_lane]        = 1'b1;
         m_cnt++;
         if (m_lane == 15 || m_cnt == len) begin
            push_exp({(m_cnt == len), m_keep, m_data}, hold);
            m_data = '0;
            m_keep = '0;
            m_lane = 0;
         end else begin
            m_lane++;
         end
         tick();
      end
      I_Monitor_OutVld = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int n;
      n = 0;
      while (!O_done && n < 60) begin
         tick();
         n++;
      end
      checks++;
      if (!O_done) begin
         errors++;
         $display("FAIL %s_done_timeout: got O_done=0 after %0d cycles, want 1", name, n);
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      checks++;
      if ({O_Monitor_En, O_word_vld, O_busy, O_done, O_overflow} !== 5'b0) begin
         errors++;
         $display("FAIL reset_flags: got en,vld,busy,done,ovf=%b, want 00000",
                  {O_Monitor_En, O_word_vld, O_busy, O_done, O_overflow});
      end
      checks++;
      if ({O_word, O_word_keep, O_word_last, O_byte_cnt} !== '0) begin
         errors++;
         $display("FAIL reset_data: got word=%h keep=%h last=%b cnt=%0d, want all 0",
                  O_word, O_word_keep, O_word_last, O_byte_cnt);
      end
      checks++;
      if (O_dbg_state !== 2'd0) begin
         errors++;
         $display("FAIL reset_state: got %0d, want 0", O_dbg_state);
      end
   endtask

   task automatic test_basic_32();
      int en0, d0;
      en0 = en_cycles;
      d0  = done_cnt;
      I_word_rdy = 1'b1;
      start_capture(16'd32);
      checks++;
      if (O_Monitor_En !== 1'b1 || O_busy !== 1'b1) begin
         errors++;
         $display("FAIL basic_en_rise: got en=%b busy=%b, want 1 1", O_Monitor_En, O_busy);
      end
      send_bytes(32, 8'h00, 32, 1'b0);
      checks++;
      if (O_Monitor_En !== 1'b0) begin
         errors++;
         $display("FAIL basic_en_fall: got %b, want 0", O_Monitor_En);
      end
      wait_done("basic");
      ticks(3);
      checks++;
      if (done_cnt - d0 != 1) begin
         errors++;
         $display("FAIL basic_done_pulses: got %0d, want 1", done_cnt - d0);
      end
      checks++;
      if (en_cycles - en0 != 32) begin
         errors++;
         $display("FAIL basic_en_cycles: got %0d, want 32", en_cycles - en0);
      end
      checks++;
      if (O_byte_cnt !== 16'd32 || O_busy !== 1'b0) begin
         errors++;
         $display("FAIL basic_end: got cnt=%0d busy=%b, want 32 0", O_byte_cnt, O_busy);
      end
   endtask

   task automatic test_overflow_64();
      I_word_rdy = 1'b0;
      start_capture(16'd64);
      send_bytes(64, 8'h00, 64, 1'b1);
      checks++;
      if (O_overflow !== exp_ovf) begin
         errors++;
         $display("FAIL ovf_flag: got %b, want %b", O_overflow, exp_ovf);
      end
      checks++;
      if ({O_word_last, O_word_keep, O_word} !== exp_q[0] || O_word_vld !== 1'b1) begin
         errors++;
         $display("FAIL ovf_hold: got vld=%b last=%b keep=%h word=%h, want vld=1 last=%b keep=%h word=%h",
                  O_word_vld, O_word_last, O_word_keep, O_word,
                  exp_q[0][144], exp_q[0][143:128], exp_q[0][127:0]);
      end
      ticks(4);
      checks++;
      if (O_done !== 1'b0 || O_busy !== 1'b1) begin
         errors++;
         $display("FAIL ovf_drain_wait: got done=%b busy=%b, want 0 1", O_done, O_busy);
      end
      I_word_rdy = 1'b1;
      wait_done("ovf");
      tick();
      checks++;
      if (exp_q.size() != 0 || O_overflow !== 1'b1) begin
         errors++;
         $display("FAIL ovf_after: got pending=%0d ovf=%b, want 0 1", exp_q.size(), O_overflow);
      end
   endtask

   task automatic test_partial_20();
      int d0;
      I_word_rdy = 1'b1;
      start_capture(16'd20);
      checks++;
      if (O_overflow !== 1'b0) begin
         errors++;
         $display("FAIL partial_ovf_clear: got %b, want 0", O_overflow);
      end
      send_bytes(5, 8'hA0, 20, 1'b0);
      // start while busy must be ignored
      d0 = done_cnt;
      I_cap_len = 16'd0;
      I_start   = 1'b1;
      send_bytes(1, 8'hA5, 20, 1'b0);
      I_start   = 1'b0;
      send_bytes(14, 8'hA6, 20, 1'b0);
      wait_done("partial");
      ticks(2);
      checks++;
      if (O_byte_cnt !== 16'd20 || O_overflow !== 1'b0 || done_cnt - d0 != 1) begin
         errors++;
         $display("FAIL partial_end: got cnt=%0d ovf=%b done=%0d, want 20 0 1",
                  O_byte_cnt, O_overflow, done_cnt - d0);
      end
   endtask

   task automatic test_abort();
      int d0;
      I_word_rdy = 1'b0;
      start_capture(16'd48);
      send_bytes(20, 8'h10, 48, 1'b0);
      checks++;
      if (O_word_vld !== 1'b1) begin
         errors++;
         $display("FAIL abort_pre_vld: got %b, want 1", O_word_vld);
      end
      d0 = done_cnt;
      I_abort = 1'b1;
      tick();
      I_abort = 1'b0;
      exp_q.delete();
      checks++;
      if ({O_Monitor_En, O_word_vld, O_busy} !== 3'b000) begin
         errors++;
         $display("FAIL abort_outputs: got en,vld,busy=%b, want 000",
                  {O_Monitor_En, O_word_vld, O_busy});
      end
      I_word_rdy = 1'b1;
      ticks(5);
      checks++;
      if (done_cnt != d0) begin
         errors++;
         $display("FAIL abort_no_done: got %0d pulses, want 0", done_cnt - d0);
      end
      // start and abort together: abort wins
      I_cap_len = 16'd5;
      I_start   = 1'b1;
      I_abort   = 1'b1;
      tick();
      I_start   = 1'b0;
      I_abort   = 1'b0;
      checks++;
      if (O_busy !== 1'b0 || O_Monitor_En !== 1'b0) begin
         errors++;
         $display("FAIL start_abort_same: got busy=%b en=%b, want 0 0", O_busy, O_Monitor_En);
      end
      start_capture(16'd16);
      send_bytes(16, 8'h40, 16, 1'b0);
      wait_done("post_abort");
      tick();
      checks++;
      if (O_byte_cnt !== 16'd16) begin
         errors++;
         $display("FAIL post_abort_cnt: got %0d, want 16", O_byte_cnt);
      end
   endtask

   task automatic test_zero_len();
      int en0;
      en0 = en_cycles;
      start_capture(16'd0);
      checks++;
      if (O_done !== 1'b1 || O_Monitor_En !== 1'b0) begin
         errors++;
         $display("FAIL zero_done: got done=%b en=%b, want 1 0", O_done, O_Monitor_En);
      end
      ticks(3);
      checks++;
      if (O_done !== 1'b0 || O_busy !== 1'b0 || O_word_vld !== 1'b0 || en_cycles != en0) begin
         errors++;
         $display("FAIL zero_after: got done=%b busy=%b vld=%b en_cycles=%0d, want 0 0 0 0",
                  O_done, O_busy, O_word_vld, en_cycles - en0);
      end
   endtask

`ifdef MON_TIMEOUT_FLUSH_EN
   task automatic test_timeout_flush();
      I_word_rdy = 1'b1;
      start_capture(16'd10);
      send_bytes(5, 8'hC0, 10, 1'b0);
      ticks(7);
      checks++;
      if (O_word_vld !== 1'b0) begin
         errors++;
         $display("FAIL timeout_early: got vld=%b after 7 idle, want 0", O_word_vld);
      end
      // eighth idle cycle triggers the flush of lanes 0..4
      push_exp({1'b0, 16'h001F, m_data}, 1'b0);
      m_data = '0;
      m_keep = '0;
      m_lane = 0;
      tick();
      checks++;
      if (O_word_vld !== 1'b1 || O_word_keep !== 16'h001F || O_word_last !== 1'b0) begin
         errors++;
         $display("FAIL timeout_flush: got vld=%b keep=%h last=%b, want 1 001f 0",
                  O_word_vld, O_word_keep, O_word_last);
      end
      send_bytes(5, 8'hC5, 10, 1'b0);
      wait_done("timeout");
      tick();
   endtask
`endif

   // ---------------- main sequence ----------------
   initial begin
      errors           = 0;
      checks           = 0;
      en_cycles        = 0;
      done_cnt         = 0;
      I_rst            = 1'b1;
      I_start          = 1'b0;
      I_abort          = 1'b0;
      I_cap_len        = '0;
      I_Monitor_Out    = '0;
      I_Monitor_OutVld = 1'b0;
      I_word_rdy       = 1'b0;
      m_data           = '0;
      m_keep           = '0;
      m_lane           = 0;
      m_cnt            = 0;
      exp_ovf          = 1'b0;
      #23;
      test_reset();
      I_rst = 1'b0;
      @(posedge I_clk);
      #1;
      test_reset();
      test_basic_32();
      test_overflow_64();
      test_partial_20();
      test_abort();
      test_zero_len();
`ifdef MON_TIMEOUT_FLUSH_EN
      test_timeout_flush();
`endif
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL sb_leftover: got %0d words never seen, want 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
